// File: rtl/xilinx_primitive_pkg.sv
// Shared constants and helpers for Xilinx primitive wrappers.
// Latency: n/a (compile-time constants only).
// Backpressure: n/a.
package xilinx_primitive_pkg;

    // FIFO18E1/FIFO36E1 in standard mode with the output register enabled.
    localparam int FIFO_READ_LATENCY_DOREG1 = 2;

    // Capture buffer depth that keeps full throughput with RDEN credited against it:
    // one entry per in-flight read, one for the word being popped and one spare.
    function automatic int get_skid_depth(input int read_latency);
        return read_latency + 2;
    endfunction

endpackage

// File: rtl/xilinx_skid_buffer.sv
// Circular capture buffer: words pushed at an edge become visible on valid/data at that same edge.
// Latency: 1 cycle push-to-valid, no bypass; data is read from the entry at rd_ptr.
// Backpressure: none on push (caller must credit); pop only when valid; push while full drops the word.
module xilinx_skid_buffer
    import xilinx_primitive_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int DEPTH      = 4
) (
    input  logic                           CLK,
    input  logic                           RSTN,
    input  logic                           push,
    input  logic [DATA_WIDTH-1:0]          push_data,
    input  logic                           pop,
    output logic                           valid,
    output logic [DATA_WIDTH-1:0]          data,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  full;
    logic                  do_push;
    logic                  do_pop;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Qualify push/pop: a push into a full buffer is discarded, a pop from empty is ignored.
    always_comb begin
        full    = (count == CNT_W'(DEPTH));
        valid   = (count != '0);
        do_push = push && !full;
        do_pop  = pop && valid;
        data    = mem[rd_ptr];
    end

    // Storage write; entries are cleared on reset so data reads zero out of reset.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking; simultaneous push and pop leaves count unchanged.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // The upstream credit scheme must never let a word arrive while the buffer is full.
    overflow_check: assert property (@(posedge CLK) disable iff (!RSTN) !(push && full));

endmodule

// File: rtl/xilinx_fifo_read_stream.sv
// Read-side master for a non-FWFT FIFO18E1/FIFO36E1: credits RDEN, captures DO, emits a valid/ready stream.
// Latency: EMPTY falling to first M_VALID is READ_LATENCY+1 cycles; sustained 1 word/cycle.
// Backpressure: RDEN stops once buffered + in-flight words reach SKID_DEPTH; in-flight words always land.
module xilinx_fifo_read_stream
    import xilinx_primitive_pkg::*;
#(
    parameter int DATA_WIDTH   = 4,
    parameter int READ_LATENCY = FIFO_READ_LATENCY_DOREG1,
    parameter int SKID_DEPTH   = get_skid_depth(READ_LATENCY)
) (
    input  logic                              CLK,
    input  logic                              RSTN,
    input  logic                              FIFO_EMPTY,
    output logic                              FIFO_RDEN,
    input  logic [DATA_WIDTH-1:0]             FIFO_DO,
    input  logic                              FIFO_RDERR,
    output logic                              M_VALID,
    input  logic                              M_READY,
    output logic [DATA_WIDTH-1:0]             M_DATA,
    output logic [$clog2(SKID_DEPTH+1)-1:0]   OCCUPANCY,
    output logic                              RD_ERR
);

    localparam int CNT_W = $clog2(SKID_DEPTH + 1);
    // One extra bit so occupancy + inflight can never wrap before the compare.
    localparam int CMP_W = CNT_W + 1;

    if (DATA_WIDTH < 1 || DATA_WIDTH > 72) begin : g_bad_width
        $error("xilinx_fifo_read_stream: DATA_WIDTH must be 1..72");
    end
    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
        $error("xilinx_fifo_read_stream: READ_LATENCY must be 1..4");
    end
    if (SKID_DEPTH < READ_LATENCY + 2) begin : g_bad_depth
        $error("xilinx_fifo_read_stream: SKID_DEPTH must be >= READ_LATENCY+2");
    end

    logic [READ_LATENCY-1:0] tag_pipe;
    logic [CMP_W-1:0]        inflight;
    logic                    credit_ok;
    logic                    tag_out;

    // Count outstanding reads and grant RDEN only when every in-flight word has a buffer slot.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight = inflight + CMP_W'(tag_pipe[i]);
        end
        credit_ok = ({1'b0, OCCUPANCY} + inflight) < CMP_W'(SKID_DEPTH);
        FIFO_RDEN = !FIFO_EMPTY && credit_ok && RSTN;
        tag_out   = tag_pipe[READ_LATENCY-1];
    end

    // Tag pipe mirrors the FIFO read latency; it never stalls since the FIFO cannot be held.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            tag_pipe <= '0;
        end else begin
            tag_pipe[0] <= FIFO_RDEN;
            for (int i = 1; i < READ_LATENCY; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    // Sticky read-error flag, cleared only by reset.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            RD_ERR <= 1'b0;
        end else if (FIFO_RDERR) begin
            RD_ERR <= 1'b1;
        end
    end

    xilinx_skid_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (SKID_DEPTH)
    ) u_skid (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .push      (tag_out),
        .push_data (FIFO_DO),
        .pop       (M_VALID && M_READY),
        .valid     (M_VALID),
        .data      (M_DATA),
        .count     (OCCUPANCY)
    );

endmodule

// File: tb/tb_xilinx_fifo_read_stream.sv
// Directed and table-driven checks of the FIFO read-stream master against a behavioural FIFO model.
// Latency: model FIFO returns DO two cycles after RDEN is sampled.
// Backpressure: M_READY driven per test (held low, high, or random).
module tb_xilinx_fifo_read_stream;

    localparam int DW = 4;
    localparam int RL = 2;
    localparam int SD = 4;
    localparam int OW = $clog2(SD + 1);

    logic          CLK = 1'b0;
    logic          RSTN;
    logic          FIFO_EMPTY;
    logic          FIFO_RDEN;
    logic [DW-1:0] FIFO_DO;
    logic          FIFO_RDERR;
    logic          M_VALID;
    logic          M_READY;
    logic [DW-1:0] M_DATA;
    logic [OW-1:0] OCCUPANCY;
    logic          RD_ERR;

    xilinx_fifo_read_stream #(
        .DATA_WIDTH   (DW),
        .READ_LATENCY (RL),
        .SKID_DEPTH   (SD)
    ) dut (
        .CLK        (CLK),
        .RSTN       (RSTN),
        .FIFO_EMPTY (FIFO_EMPTY),
        .FIFO_RDEN  (FIFO_RDEN),
        .FIFO_DO    (FIFO_DO),
        .FIFO_RDERR (FIFO_RDERR),
        .M_VALID    (M_VALID),
        .M_READY    (M_READY),
        .M_DATA     (M_DATA),
        .OCCUPANCY  (OCCUPANCY),
        .RD_ERR     (RD_ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int n_words;
        int run_cycles;
        int exp_rden;
        int exp_occ;
        bit exp_vld;
    } bp_vec_t;

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] st0 = '0;
    bit            t0 = 1'b0;
    bit            t1 = 1'b0;
    bit            gap_en = 1'b0;
    int            cyc = 0;
    int            rden_cnt = 0;
    int            out_cnt = 0;
    int            first_vld = -1;
    int            first_pop = -1;
    int            last_pop = -1;
    int            viol_empty = 0;
    int            viol_credit = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // One clock: sample at negedge, then advance the FIFO model just after posedge.
    task automatic cycle();
        logic          rs;
        logic          hs;
        logic [DW-1:0] d;
        @(negedge CLK);
        rs = FIFO_RDEN;
        hs = M_VALID && M_READY;
        d  = M_DATA;
        if (FIFO_RDEN && FIFO_EMPTY) viol_empty++;
        if (int'(OCCUPANCY) + int'(t0) + int'(t1) > SD) viol_credit++;
        if (M_VALID && first_vld < 0) first_vld = cyc;
        if (hs) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_word: got %0d, required no word", d);
            end else begin
                check("stream_word", d, exp_q.pop_front());
                out_cnt++;
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
            end
        end
        if (rs) rden_cnt++;
        @(posedge CLK);
        #1;
        cyc++;
        FIFO_DO = st0;
        st0 = '0;
        if (rs && fifo_q.size() > 0) st0 = fifo_q.pop_front();
        t1 = t0;
        t0 = rs;
        FIFO_EMPTY = (fifo_q.size() == 0) || (gap_en && $urandom_range(0, 3) == 0);
    endtask

    task automatic load(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back(DW'(base + i));
            exp_q.push_back(DW'(base + i));
        end
        FIFO_EMPTY = (fifo_q.size() == 0);
    endtask

    task automatic drain(input int bound, input string name);
        M_READY = 1'b1;
        for (int i = 0; i < bound; i++) begin
            if (exp_q.size() == 0) break;
            cycle();
        end
        check(name, exp_q.size(), 0);
    endtask

    bp_vec_t vecs[5];

    initial begin
        vecs[0] = '{10, 12, 4, 4, 1'b1};
        vecs[1] = '{2,  10, 2, 2, 1'b1};
        vecs[2] = '{4,  10, 4, 4, 1'b1};
        vecs[3] = '{1,   8, 1, 1, 1'b1};
        vecs[4] = '{0,   6, 0, 0, 1'b0};

        RSTN       = 1'b0;
        FIFO_EMPTY = 1'b1;
        FIFO_DO    = '0;
        FIFO_RDERR = 1'b0;
        M_READY    = 1'b0;

        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        check("rst_rden", FIFO_RDEN, 0);
        check("rst_valid", M_VALID, 0);
        check("rst_data", M_DATA, 0);
        check("rst_occ", OCCUPANCY, 0);
        check("rst_rderr", RD_ERR, 0);
        @(negedge CLK);
        RSTN = 1'b1;
        @(posedge CLK);
        #1;

        // Burst of 8 with M_READY high
        M_READY = 1'b1;
        first_vld = -1; first_pop = -1; out_cnt = 0;
        load(8, 1);
        begin
            int load_cyc;
            load_cyc = cyc;
            for (int i = 0; i < 40 && exp_q.size() > 0; i++) cycle();
            check("burst_latency", first_vld - load_cyc, 3);
            check("burst_back_to_back", last_pop - first_pop, 7);
            check("burst_count", out_cnt, 8);
        end
        repeat (3) cycle();

        // Back-pressure table: M_READY low, then drain in order
        for (int r = 0; r < 5; r++) begin
            M_READY = 1'b0;
            rden_cnt = 0;
            load(vecs[r].n_words, 1);
            repeat (vecs[r].run_cycles) cycle();
            check("bp_rden_pulses", rden_cnt, vecs[r].exp_rden);
            check("bp_occupancy", OCCUPANCY, vecs[r].exp_occ);
            check("bp_valid", M_VALID, vecs[r].exp_vld);
            check("bp_data_held", M_DATA, (vecs[r].n_words > 0) ? 1 : M_DATA);
            drain(60, "bp_drained");
            repeat (3) cycle();
            check("bp_empty_after", OCCUPANCY, 0);
        end

        // Drain to empty: 3 words, EMPTY rises after the 3rd RDEN
        M_READY = 1'b1;
        rden_cnt = 0; out_cnt = 0; viol_empty = 0;
        load(3, 9);
        repeat (15) cycle();
        check("drain3_rden", rden_cnt, 3);
        check("drain3_words", out_cnt, 3);
        check("drain3_rden_while_empty", viol_empty, 0);

        // Random ready and empty gaps, 1000 words
        viol_credit = 0; viol_empty = 0; out_cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            logic [DW-1:0] w;
            w = DW'($urandom);
            fifo_q.push_back(w);
            exp_q.push_back(w);
        end
        FIFO_EMPTY = 1'b0;
        gap_en = 1'b1;
        for (int i = 0; i < 20000 && exp_q.size() > 0; i++) begin
            M_READY = 1'($urandom_range(0, 1));
            cycle();
        end
        gap_en = 1'b0;
        check("rand_drained", exp_q.size(), 0);
        check("rand_words", out_cnt, 1000);
        check("rand_credit", viol_credit, 0);
        check("rand_rden_while_empty", viol_empty, 0);
        M_READY = 1'b1;
        repeat (4) cycle();

        // Sticky read error
        FIFO_RDERR = 1'b1;
        cycle();
        FIFO_RDERR = 1'b0;
        check("rderr_set", RD_ERR, 1);
        repeat (3) cycle();
        check("rderr_held", RD_ERR, 1);

        // Reset mid-operation: 2 buffered, 2 in flight
        M_READY = 1'b0;
        rden_cnt = 0;
        load(10, 1);
        repeat (4) cycle();
        check("mid_rden", rden_cnt, 4);
        check("mid_occ", OCCUPANCY, 2);
        RSTN = 1'b0;
        #1;
        check("mid_rst_rden", FIFO_RDEN, 0);
        check("mid_rst_valid", M_VALID, 0);
        check("mid_rst_data", M_DATA, 0);
        check("mid_rst_occ", OCCUPANCY, 0);
        check("mid_rst_rderr", RD_ERR, 0);
        fifo_q.delete();
        exp_q.delete();
        t0 = 1'b0;
        t1 = 1'b0;
        FIFO_EMPTY = 1'b1;
        @(negedge CLK);
        RSTN = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            check("post_rst_no_valid", M_VALID, 0);
        end
        out_cnt = 0;
        load(2, 5);
        drain(30, "post_rst_drained");
        check("post_rst_words", out_cnt, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
